// File: rtl/range_frame_buffer_pkg.sv
// Shared types and default sizes for the range-finder frame buffer.
package range_pkg;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    DISCARD = 2'd1,
    REPLAY  = 2'd2,
    FINISH  = 2'd3
  } state_t;

  localparam int RANGE_W     = 8;
  localparam int RANGE_DEPTH = 16;

endpackage

// File: rtl/range_frame_mem.sv
// DEPTH x WIDTH frame storage: synchronous write, registered read.
// A same-cycle write to the read address is forwarded so a 1-sample frame replays at once.
module range_frame_mem
  import range_pkg::*;
#(
  parameter int WIDTH = RANGE_W,
  parameter int DEPTH = RANGE_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
    end
  end

endmodule

// File: rtl/range_frame_buffer.sv
// Buffers one valid/ready frame and replays it as a gap-free go/finish burst.
// Optional RANGE_FRAME_COUNT_EN adds a completed-frame counter output.
module range_frame_buffer
  import range_pkg::*;
#(
  parameter int WIDTH = RANGE_W,
  parameter int DEPTH = RANGE_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             go,
  output logic             finish,
  output logic             overflow,
  output logic             busy
`ifdef RANGE_FRAME_COUNT_EN
  ,
  output logic [7:0]       frame_count
`endif
);

  // Handshake: a sample transfers on a rising edge where in_valid && in_ready;
  // in_last is meaningful only on such a transfer.

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]   len_q, len_d;
  logic          go_d, finish_d, overflow_d, busy_d;
  logic          mem_wr_en, mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic          xfer;

  assign in_ready = (state_q == FILL) || (state_q == DISCARD);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    len_d       = len_q;
    go_d        = 1'b0;
    finish_d    = 1'b0;
    overflow_d  = 1'b0;
    mem_wr_en   = 1'b0;
    mem_rd_en   = 1'b0;
    mem_rd_addr = rd_ptr_q[AW-1:0];
    case (state_q)
      FILL: begin
        if (xfer) begin
          mem_wr_en = 1'b1;
          if (in_last) begin
            // Prefetch sample 0 now so it is on out_data with go.
            state_d     = REPLAY;
            len_d       = {1'b0, wr_ptr_q} + (AW+1)'(1);
            go_d        = 1'b1;
            mem_rd_en   = 1'b1;
            mem_rd_addr = '0;
            rd_ptr_d    = (AW+1)'(1);
          end else if (wr_ptr_q == AW'(DEPTH - 1)) begin
            state_d    = DISCARD;
            overflow_d = 1'b1;
            wr_ptr_d   = '0;
          end else begin
            wr_ptr_d = wr_ptr_q + AW'(1);
          end
        end
      end
      DISCARD: begin
        if (xfer && in_last) begin
          state_d  = FILL;
          wr_ptr_d = '0;
        end
      end
      REPLAY: begin
        // rd_ptr_q counts samples already presented on out_data.
        if (rd_ptr_q == len_q) begin
          state_d  = FINISH;
          finish_d = 1'b1;
        end else begin
          mem_rd_en = 1'b1;
          rd_ptr_d  = rd_ptr_q + (AW+1)'(1);
        end
      end
      FINISH: begin
        state_d  = FILL;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        len_d    = '0;
      end
      default: begin
        state_d = FILL;
      end
    endcase
    busy_d = (state_d == REPLAY) || (state_d == FINISH);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= FILL;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      len_q    <= '0;
      go       <= 1'b0;
      finish   <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      len_q    <= len_d;
      go       <= go_d;
      finish   <= finish_d;
      overflow <= overflow_d;
      busy     <= busy_d;
    end
  end

  range_frame_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (mem_wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (in_data),
    .rd_en   (mem_rd_en),
    .rd_addr (mem_rd_addr),
    .rd_data (out_data)
  );

`ifdef RANGE_FRAME_COUNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_count <= '0;
    end else if (finish) begin
      frame_count <= frame_count + 8'd1;
    end
  end
`endif

endmodule
